mult_div_unit: RTL and testbench

//  Iterative multiply/divide unit with HI/LO result registers for the multicycle MIPS datapath.

---
 rtl/mult_div_unit.sv | 138 +++++++++++++
 tb/tb_mult_div_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit: shift-add MULT/MULTU, restoring DIV/DIVU, HI/LO registers.
// Optional MTHI/MTLO write port is enabled by defining MDU_HILO_WRITE_EN.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
`ifdef MDU_HILO_WRITE_EN
   input  logic             hilo_wr,
   input  logic             hilo_sel,
   input  logic [WIDTH-1:0] hilo_din,
`endif
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

   state_t             state, nxt;
   logic               is_div, sgn_q, sgn_r, dz;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   opr;
   logic [2*WIDTH-1:0] acc;

   logic               start_ok, signed_op, a_neg, b_neg, b_zero, ge;
   logic [WIDTH-1:0]   a_mag, b_mag, res_hi, res_lo;
   logic [WIDTH:0]     msum, rtrial, rdiff;
   logic [2*WIDTH-1:0] mult_next, div_next, prod;

   assign start_ok  = (state == IDLE) && start;
   assign signed_op = ~op[0];
   assign a_neg     = signed_op & op_a[WIDTH-1];
   assign b_neg     = signed_op & op_b[WIDTH-1];
   assign a_mag     = a_neg ? -op_a : op_a;
   assign b_mag     = b_neg ? -op_b : op_b;
   assign b_zero    = (op_b == '0);

   assign busy = (state == CALC) || (state == FIXUP);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   // Divide-by-zero goes straight to FIXUP: the preloaded acc already holds the result,
   // which keeps done at start+2 without a separate state.
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (start) nxt = (op[1] && b_zero) ? FIXUP : CALC;
         CALC:    if (cnt == CW'(WIDTH-1)) nxt = FIXUP;
         FIXUP:   nxt = DONE;
         default: nxt = IDLE;
      endcase
   end

   // One iteration of each algorithm; acc = {upper/remainder, lower/quotient}.
   always_comb begin
      msum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opr};
      mult_next = acc[0] ? {msum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
      rtrial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      rdiff     = rtrial - {1'b0, opr};
      ge        = (rtrial >= {1'b0, opr});
      div_next  = ge ? {rdiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                     : {rtrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
   end

   always_comb begin
      prod   = sgn_q ? -acc : acc;
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
      if (dz) begin
         res_hi = acc[2*WIDTH-1:WIDTH];
         res_lo = acc[WIDTH-1:0];
      end else if (is_div) begin
         res_lo = sgn_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
         res_hi = sgn_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_div <= 1'b0;
         sgn_q  <= 1'b0;
         sgn_r  <= 1'b0;
         dz     <= 1'b0;
         cnt    <= '0;
         opr    <= '0;
         acc    <= '0;
      end else if (start_ok) begin
         is_div <= op[1];
         sgn_q  <= a_neg ^ b_neg;
         sgn_r  <= a_neg;
         dz     <= op[1] & b_zero;
         cnt    <= '0;
         if (op[1]) begin
            opr <= b_mag;
            acc <= b_zero ? {op_a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, a_mag};
         end else begin
            opr <= a_mag;
            acc <= {{WIDTH{1'b0}}, b_mag};
         end
      end else if (state == CALC) begin
         cnt <= cnt + CW'(1);
         acc <= is_div ? div_next : mult_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi       <= '0;
         lo       <= '0;
         div_zero <= 1'b0;
      end else begin
         if (start_ok) div_zero <= 1'b0;
         if (state == FIXUP) begin
            hi       <= res_hi;
            lo       <= res_lo;
            div_zero <= dz;
         end
`ifdef MDU_HILO_WRITE_EN
         else if (hilo_wr && (state == IDLE || state == DONE)) begin
            if (hilo_sel) hi <= hilo_din;
            else          lo <= hilo_din;
         end
`endif
      end
   end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table of MULT/DIV results plus
// hand sequences for ignored start, async reset abort and the optional HI/LO write.
module tb_mult_div_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] op_a = '0, op_b = '0;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;
`ifdef MDU_HILO_WRITE_EN
   logic        hilo_wr = 1'b0, hilo_sel = 1'b0;
   logic [31:0] hilo_din = '0;
`endif

   mult_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
`ifdef MDU_HILO_WRITE_EN
      .hilo_wr(hilo_wr), .hilo_sel(hilo_sel), .hilo_din(hilo_din),
`endif
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo));

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a, b, hi, lo;
      logic        dz;
      int          lat;
   } vec_t;

   vec_t        vecs [13];
   int          n_chk = 0, n_fail = 0;
   logic [31:0] prev_hi = '0, prev_lo = '0;
   logic        inj = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Start an op, then walk cycles (sampled on negedge) until done; k = cycles after start edge.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busyc);
      lat = -1;
      busyc = 0;
      @(negedge clk);
      op = o; op_a = a; op_b = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h0BAD_F00D;
      for (int k = 1; k <= 60; k++) begin
         if (k == 1) begin
            check("hold_hi", hi, prev_hi);
            check("hold_lo", lo, prev_lo);
            check("dz_clear", div_zero, 1'b0);
         end
         if (inj && k == 5) begin
            start = 1'b1; op = 2'b01; op_a = 32'd9; op_b = 32'd9;
         end
         if (inj && k == 6) start = 1'b0;
         if (done) begin
            lat = k;
            break;
         end
         if (busy) busyc++;
         @(negedge clk);
      end
   endtask

   initial begin
      int lat, bc, dcount;
      vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34};
      vecs[1]  = '{2'b00, 32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
      vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
      vecs[3]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34};
      vecs[4]  = '{2'b11, 32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFF, 1'b1, 2};
      vecs[5]  = '{2'b01, 32'd3,        32'd5,        32'd0,        32'd15,       1'b0, 34};
      vecs[6]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 34};
      vecs[7]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 34};
      vecs[8]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0, 34};
      vecs[9]  = '{2'b10, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 2};
      vecs[10] = '{2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 34};
      vecs[11] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34};
      vecs[12] = '{2'b11, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0, 34};

      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_dz", div_zero, 1'b0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // vecs[3] also carries a start pulse mid-operation that must be ignored;
      // each next vector starts in the cycle right after done.
      for (int i = 0; i < 13; i++) begin
         inj = (i == 3);
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc);
         inj = 1'b0;
         check($sformatf("lat[%0d]", i), lat, vecs[i].lat);
         check($sformatf("busy[%0d]", i), bc, vecs[i].lat - 1);
         check($sformatf("hi[%0d]", i), hi, vecs[i].hi);
         check($sformatf("lo[%0d]", i), lo, vecs[i].lo);
         check($sformatf("dz[%0d]", i), div_zero, vecs[i].dz);
         prev_hi = vecs[i].hi;
         prev_lo = vecs[i].lo;
      end

      // Async reset in the middle of an operation.
      @(negedge clk);
      op = 2'b01; op_a = 32'd11; op_b = 32'd13; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dcount = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) dcount++;
      end
      check("abort_no_done", dcount, 0);

`ifdef MDU_HILO_WRITE_EN
      @(negedge clk);
      hilo_wr = 1'b1; hilo_sel = 1'b1; hilo_din = 32'hABCD;
      @(negedge clk);
      hilo_wr = 1'b0;
      check("mthi_hi", hi, 32'hABCD);
      check("mthi_lo", lo, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
